// File: rtl/cpu_pkg.sv
// Purpose: shared constants and loader state encoding for the CPU boot path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;   // byte, RAM data and RAM address width
  localparam int RAM_DEPTH  = 256; // CPU RAM words; also the largest frame length

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN  = 3'd1,
    LD_DATA = 3'd2,
    LD_SUM  = 3'd3,
    LD_RUN  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/prog_loader_csum.sv
// Purpose: modulo-2^W frame checksum accumulator (clear / accumulate / compare).
// Latency: accumulation lands 1 cycle after acc_i; ok_o is combinational on dat_i.
// Backpressure: none; caller qualifies acc_i with its own handshake.
// Ports: clk, rst (sync, active-high); clr_i zeroes the sum; acc_i adds dat_i;
//        ok_o is high when sum + dat_i == 0 (dat_i is the frame's closing checksum).
module ld_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         acc_i,
  input  logic [W-1:0] dat_i,
  output logic         ok_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;
  logic [W-1:0] total;

  // Wraps at W bits: the checksum is the two's complement of the frame sum.
  assign total = sum_q + dat_i;
  assign ok_o  = (total == '0);

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (acc_i) begin
      sum_d = total;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Purpose: boot loader; takes a [len, payload..., checksum] byte frame and writes the payload to CPU RAM.
// Latency: start->in_ready 1 cycle; payload byte->RAM write 1 cycle; checksum accepted->run 1 cycle.
// Backpressure: in_ready is high only in LEN/DATA/SUM; every payload byte is written the cycle after it transfers.
// Ports: clk/rst (sync, active-high); start/abort control; in_valid/in_ready/in_data stream;
//        ram_addr/ram_data/ram_wren RAM write port; cpu_hold, run, busy, err (sticky) status.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = CPU_DATA_W,
  parameter logic [DATA_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              run,
  output logic              busy,
  output logic              err
);

  localparam logic [DATA_W-1:0] PTR_ONE  = 1;
  localparam logic [DATA_W:0]   CNT_ONE  = 1;
  localparam logic [DATA_W:0]   CNT_FULL = (DATA_W + 1)'(RAM_DEPTH);

  ld_state_e         state_q;
  logic [DATA_W:0]   cnt_q;      // payload bytes still expected; 9 bits so length 0 can mean 256
  logic [DATA_W-1:0] ptr_q;      // next RAM address to write
  logic              in_ready_q;
  logic [DATA_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_wren_q;
  logic              cpu_hold_q;
  logic              run_q;
  logic              busy_q;
  logic              err_q;

  logic xfer;
  logic abort_hit;
  logic csum_clr;
  logic csum_acc;
  logic csum_ok;

  assign xfer      = in_valid && in_ready_q;
  assign abort_hit = abort && (state_q != LD_IDLE);
  assign csum_clr  = (state_q == LD_IDLE) && start;
  // An aborted byte is dropped, so it must not reach the running sum either.
  assign csum_acc  = xfer && !abort_hit && ((state_q == LD_LEN) || (state_q == LD_DATA));

  ld_csum #(.W(DATA_W)) u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (csum_clr),
    .acc_i (csum_acc),
    .dat_i (in_data),
    .ok_o  (csum_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      in_ready_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Both strobes are single-cycle; only the states below re-arm them.
      ram_wren_q <= 1'b0;
      run_q      <= 1'b0;
      if (abort_hit) begin
        state_q    <= LD_IDLE;
        in_ready_q <= 1'b0;
        cpu_hold_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          LD_IDLE: begin
            if (start) begin
              state_q    <= LD_LEN;
              in_ready_q <= 1'b1;
              cpu_hold_q <= 1'b1;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
            end
          end
          LD_LEN: begin
            if (xfer) begin
              cnt_q   <= (in_data == '0) ? CNT_FULL : {1'b0, in_data};
              ptr_q   <= BASE_ADDR;
              state_q <= LD_DATA;
            end
          end
          LD_DATA: begin
            if (xfer) begin
              ram_wren_q <= 1'b1;
              ram_data_q <= in_data;
              ram_addr_q <= ptr_q;
              ptr_q      <= ptr_q + PTR_ONE;
              cnt_q      <= cnt_q - CNT_ONE;
              if (cnt_q == CNT_ONE) begin
                state_q <= LD_SUM;
              end
            end
          end
          LD_SUM: begin
            if (xfer) begin
              in_ready_q <= 1'b0;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
              if (csum_ok) begin
                run_q   <= 1'b1;
                state_q <= LD_RUN;
              end else begin
                err_q   <= 1'b1;
                state_q <= LD_IDLE;
              end
            end
          end
          LD_RUN: begin
            state_q <= LD_IDLE;
          end
          default: begin
            state_q <= LD_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign cpu_hold = cpu_hold_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Purpose: directed self-checking bench for prog_loader (BASE_ADDR 00 and FE instances on one stream).
// Latency: n/a.
// Backpressure: stream driver waits on in_ready with a bounded cycle budget.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready0, ram_wren0, cpu_hold0, run0, busy0, err0;
  logic [7:0] ram_addr0, ram_data0;
  logic       in_ready1, ram_wren1, cpu_hold1, run1, busy1, err1;
  logic [7:0] ram_addr1, ram_data1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run_cnt0 = 0;
  int run_cnt1 = 0;
  int overlap = 0;
  logic [7:0] wa0[$];
  logic [7:0] wd0[$];
  int         wc0[$];
  logic [7:0] wa1[$];
  logic [7:0] wd1[$];

  prog_loader #(.DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_wren(ram_wren0),
    .cpu_hold(cpu_hold0), .run(run0), .busy(busy0), .err(err0)
  );

  prog_loader #(.DATA_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wren(ram_wren1),
    .cpu_hold(cpu_hold1), .run(run1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/run log, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_wren0) begin wa0.push_back(ram_addr0); wd0.push_back(ram_data0); wc0.push_back(cyc); end
    if (ram_wren1) begin wa1.push_back(ram_addr1); wd1.push_back(ram_data1); end
    if (run0) run_cnt0++;
    if (run1) run_cnt1++;
    if ((run0 && ram_wren0) || (run1 && ram_wren1)) overlap++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wc0.delete(); wa1.delete(); wd1.delete();
    run_cnt0 = 0; run_cnt1 = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (!in_ready0 && g < 20) begin @(negedge clk); g++; end
    if (!in_ready0) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready0, g);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'hEE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    vectors++;
    if ({in_ready0, ram_addr0, ram_data0, ram_wren0, cpu_hold0, run0, busy0, err0} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: got %b %h %h %b %b %b %b %b, expected all 0",
               in_ready0, ram_addr0, ram_data0, ram_wren0, cpu_hold0, run0, busy0, err0);
    end
    vectors++;
    if ({in_ready1, ram_addr1, ram_data1, ram_wren1, cpu_hold1, run1, busy1, err1} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %b %h %h %b %b %b %b %b, expected all 0",
               in_ready1, ram_addr1, ram_data1, ram_wren1, cpu_hold1, run1, busy1, err1);
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_nominal();
    logic [7:0] ed[3];
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    clear_log();
    do_start();
    vectors++;
    if (in_ready0 !== 1'b1 || cpu_hold0 !== 1'b1 || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL nom_start: ready/hold/busy=%b%b%b, expected 111", in_ready0, cpu_hold0, busy0);
    end
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(ed[i]);
    vectors++;
    if (cpu_hold0 !== 1'b1 || run_cnt0 !== 0) begin
      miscompares++;
      $display("FAIL nom_hold: cpu_hold=%b runs=%0d, expected 1 and 0", cpu_hold0, run_cnt0);
    end
    send_byte(8'h97);   // -(03+11+22+33) = -69 = 97
    vectors++;
    if (run0 !== 1'b1 || cpu_hold0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b0 || in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_run: run/hold/busy/err/ready=%b%b%b%b%b, expected 10000",
               run0, cpu_hold0, busy0, err0, in_ready0);
    end
    idle_cycles(1);
    vectors++;
    if (run0 !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_run_width: run=%b one cycle later, expected 0", run0);
    end
    idle_cycles(2);
    vectors++;
    if (wa0.size() !== 3 || run_cnt0 !== 1) begin
      miscompares++;
      $display("FAIL nom_counts: writes=%0d runs=%0d, expected 3 and 1", wa0.size(), run_cnt0);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wa0[i] !== 8'(i) || wd0[i] !== ed[i] || wc0[i] !== wc0[0] + i) begin
        miscompares++;
        $display("FAIL nom_write%0d: %h@%h cyc+%0d, expected %h@%h cyc+%0d",
                 i, wd0[i], wa0[i], wc0[i] - wc0[0], ed[i], 8'(i), i);
      end
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_start();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h88);
    vectors++;
    if (err0 !== 1'b1 || cpu_hold0 !== 1'b0 || busy0 !== 1'b0 || run0 !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_flags: err/hold/busy/run=%b%b%b%b, expected 1000", err0, cpu_hold0, busy0, run0);
    end
    idle_cycles(4);
    vectors++;
    if (err0 !== 1'b1 || wa0.size() !== 3 || run_cnt0 !== 0) begin
      miscompares++;
      $display("FAIL bad_sticky: err=%b writes=%0d runs=%0d, expected 1, 3, 0", err0, wa0.size(), run_cnt0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ed[3];
    logic [7:0] ea[3];
    ed[0] = 8'hA0; ed[1] = 8'hA1; ed[2] = 8'hA2;
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    clear_log();
    do_start();
    vectors++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_on_start: err0=%b err1=%b, expected 0 0", err0, err1);
    end
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(ed[i]);
    send_byte(8'h1A);   // 03+A0+A1+A2 = E6, -E6 = 1A
    idle_cycles(3);
    vectors++;
    if (wa1.size() !== 3 || run_cnt1 !== 1 || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_counts: writes=%0d runs=%0d err=%b, expected 3, 1, 0", wa1.size(), run_cnt1, err1);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wa1[i] !== ea[i] || wd1[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL wrap_write%0d: %h@%h, expected %h@%h", i, wd1[i], wa1[i], ed[i], ea[i]);
      end
    end
  endtask

  task automatic test_len256();
    int bad;
    bad = 0;
    clear_log();
    do_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    send_byte(8'h00);   // 256 * 01 = 00 mod 256, so checksum 00
    idle_cycles(3);
    vectors++;
    if (wa0.size() !== 256 || run_cnt0 !== 1 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL len256_counts: writes=%0d runs=%0d err=%b, expected 256, 1, 0", wa0.size(), run_cnt0, err0);
    end
    for (int i = 0; i < 256; i++) begin
      if (wa0[i] !== 8'(i) || wd0[i] !== 8'h01) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL len256_data: %0d bad writes, expected 0", bad);
    end
  endtask

  task automatic test_throttled();
    logic [7:0] ed[4];
    ed[0] = 8'h10; ed[1] = 8'h20; ed[2] = 8'h30; ed[3] = 8'h40;
    clear_log();
    do_start();
    send_byte(8'h04);
    for (int i = 0; i < 4; i++) begin
      send_byte(ed[i]);
      idle_cycles(1);   // valid low with junk data for one cycle
    end
    send_byte(8'h5C);   // 04+10+20+30+40 = A4, -A4 = 5C
    idle_cycles(3);
    vectors++;
    if (wa0.size() !== 4 || run_cnt0 !== 1) begin
      miscompares++;
      $display("FAIL thr_counts: writes=%0d runs=%0d, expected 4 and 1", wa0.size(), run_cnt0);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wa0[i] !== 8'(i) || wd0[i] !== ed[i] || (i > 0 && wc0[i] !== wc0[i-1] + 2)) begin
        miscompares++;
        $display("FAIL thr_write%0d: %h@%h, expected %h@%h two cycles apart", i, wd0[i], wa0[i], ed[i], 8'(i));
      end
    end
  endtask

  task automatic test_abort_reset();
    clear_log();
    do_start();
    send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
    // Abort coincides with a valid byte; the byte must be dropped.
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    vectors++;
    if (busy0 !== 1'b0 || cpu_hold0 !== 1'b0 || in_ready0 !== 1'b0 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: busy/hold/ready/err=%b%b%b%b, expected 0000", busy0, cpu_hold0, in_ready0, err0);
    end
    idle_cycles(4);
    vectors++;
    if (wa0.size() !== 2 || wd0[0] !== 8'hAA || wd0[1] !== 8'hBB || wa0[1] !== 8'h01 || run_cnt0 !== 0) begin
      miscompares++;
      $display("FAIL abort_writes: n=%0d d1=%h@%h runs=%0d, expected 2, BB@01, 0",
               wa0.size(), wd0[1], wa0[1], run_cnt0);
    end
    clear_log();
    do_start();
    send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    vectors++;
    if ({in_ready0, ram_addr0, ram_data0, ram_wren0, cpu_hold0, run0, busy0, err0} !== 22'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b %h %h %b %b %b %b %b, expected all 0",
               in_ready0, ram_addr0, ram_data0, ram_wren0, cpu_hold0, run0, busy0, err0);
    end
    idle_cycles(4);
    vectors++;
    if (wa0.size() !== 2 || run_cnt0 !== 0) begin
      miscompares++;
      $display("FAIL midrst_writes: writes=%0d runs=%0d, expected 2 and 0", wa0.size(), run_cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_wrap();
    test_len256();
    test_throttled();
    test_abort_reset();
    test_nominal();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL run_wren_overlap: %0d cycles, expected 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
